// File: rtl/usb_tx_control_fsm_if.sv
// usb_tx_control_fsm_if: handshake bundle between the protocol controller / TX buffer / serializer and the USB TX control FSM.
//   master : protocol controller, TX buffer and serializer side (drives requests, buffer head, serializer status)
//   slave  : usb_tx_control_fsm (drives bytes, pops, EOP request, status pulses)
interface usb_tx_control_fsm_if;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       clear_toggle;
  logic       shifter_ready;
  logic       eop_done;
  logic       load_byte;
  logic [7:0] tx_byte;
  logic       get_tx_packet_data;
  logic       send_eop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  modport master (
    output tx_start, tx_packet, buffer_occupancy, tx_packet_data, clear_toggle, shifter_ready, eop_done,
    input  load_byte, tx_byte, get_tx_packet_data, send_eop, tx_busy, tx_done, tx_error
  );
  modport slave (
    input  tx_start, tx_packet, buffer_occupancy, tx_packet_data, clear_toggle, shifter_ready, eop_done,
    output load_byte, tx_byte, get_tx_packet_data, send_eop, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/usb_tx_control_fsm.sv
// usb_tx_control_fsm: sequences SYNC, PID, payload, CRC16 and EOP into the USB byte serializer.
//   clk   : system clock
//   n_rst : asynchronous active-low reset
//   bus   : usb_tx_control_fsm_if.slave (request, TX buffer head/pop, serializer handshake, status)
//   MAX_PAYLOAD : payload bytes per DATA packet; larger occupancy is clamped
//   Optional macro TX_DATA_TOGGLE_EN: DATA0/DATA1 alternation per completed DATA packet.
module usb_tx_control_fsm #(
  parameter int MAX_PAYLOAD = 64
) (
  input logic clk,
  input logic n_rst,
  usb_tx_control_fsm_if.slave bus
);
  typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, WAIT_EOP, DONE} state_t;
  localparam logic [6:0] MAX_P = 7'(MAX_PAYLOAD);
  state_t     r_state, w_next;
  logic [2:0] r_type;
  logic [6:0] r_cnt;
  logic [15:0] r_crc;
  logic       r_error;
  logic       w_valid, w_is_data, w_load, w_pop, w_eop, w_done;
  logic [7:0] w_byte, w_pid, w_data_pid;
  logic [6:0] w_occ;
  logic       w_start_ok;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'hA001 : 16'h0000);
    return r;
  endfunction
  assign w_valid    = bus.tx_packet == 3'd1 || bus.tx_packet == 3'd4 || bus.tx_packet == 3'd5 || bus.tx_packet == 3'd7;
  assign w_start_ok = r_state == IDLE && bus.tx_start && w_valid;
  assign w_occ      = bus.buffer_occupancy > MAX_P ? MAX_P : bus.buffer_occupancy;
  assign w_is_data  = r_type == 3'd1;
`ifdef TX_DATA_TOGGLE_EN
  logic r_toggle;
  assign w_data_pid = r_toggle ? 8'h4B : 8'hC3;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_toggle <= 1'b0;
    else if (bus.clear_toggle) r_toggle <= 1'b0;
    else if (r_state == DONE && w_is_data) r_toggle <= ~r_toggle;
`else
  assign w_data_pid = 8'hC3;
`endif
  assign w_pid = r_type == 3'd4 ? 8'hD2 : r_type == 3'd5 ? 8'h5A : r_type == 3'd7 ? 8'h1E : w_data_pid;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_pop  = 1'b0;
    w_eop  = 1'b0;
    w_done = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      IDLE:     if (w_start_ok) w_next = SYNC;
      SYNC: begin
        w_byte = 8'h80;
        w_load = bus.shifter_ready;
        if (bus.shifter_ready) w_next = PID;
      end
      PID: begin
        w_byte = w_pid;
        w_load = bus.shifter_ready;
        if (bus.shifter_ready) w_next = !w_is_data ? EOP : r_cnt != 7'd0 ? DATA : CRC_LO;
      end
      DATA: begin
        w_byte = bus.tx_packet_data;
        w_load = bus.shifter_ready;
        w_pop  = bus.shifter_ready;
        if (bus.shifter_ready && r_cnt == 7'd1) w_next = CRC_LO;
      end
      CRC_LO: begin
        w_byte = ~r_crc[7:0];
        w_load = bus.shifter_ready;
        if (bus.shifter_ready) w_next = CRC_HI;
      end
      CRC_HI: begin
        w_byte = ~r_crc[15:8];
        w_load = bus.shifter_ready;
        if (bus.shifter_ready) w_next = EOP;
      end
      EOP: begin
        w_eop  = 1'b1;
        w_next = WAIT_EOP;
      end
      WAIT_EOP: if (bus.eop_done) w_next = DONE;
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end
  // Invalid requests are flagged one cycle later so no output depends on tx_start combinationally.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_state <= IDLE;
      r_type  <= 3'd0;
      r_cnt   <= 7'd0;
      r_crc   <= 16'hFFFF;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= r_state == IDLE && bus.tx_start && !w_valid;
      if (w_start_ok) begin
        r_type <= bus.tx_packet;
        r_cnt  <= w_occ;
        r_crc  <= 16'hFFFF;
      end else if (w_pop) begin
        r_crc <= crc_byte(r_crc, bus.tx_packet_data);
        r_cnt <= r_cnt - 7'd1;
      end
    end
  assign bus.load_byte          = w_load;
  assign bus.tx_byte            = w_byte;
  assign bus.get_tx_packet_data = w_pop;
  assign bus.send_eop           = w_eop;
  assign bus.tx_busy            = r_state != IDLE;
  assign bus.tx_done            = w_done;
  assign bus.tx_error           = r_error;
endmodule

// File: doc/usb_tx_control_fsm.md
# usb_tx_control_fsm

Control FSM for the USB TX path: on a transmit request from the protocol controller it sequences SYNC, PID, optional data payload from the TX buffer, CRC16 and EOP into the byte serializer. It sits between the protocol controller or TX buffer and the bit-level shifter that performs NRZI encoding and bit stuffing. It is the transmit-side counterpart of the RX control FSM and uses the same 3-bit packet-type encoding.

## Interface
- Parameters:
- `MAX_PAYLOAD`, default 64: maximum data bytes per DATA packet. Larger occupancy is clamped to this value.
- Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `tx_start`  in  1  one-cycle request; sampled only in IDLE
- `tx_packet`  in  3  packet type, sampled with `tx_start`: 1=DATA, 4=ACK, 5=NAK, 7=STALL; all other codes are invalid
- `buffer_occupancy`  in  7  bytes in the TX buffer, sampled with `tx_start`
- `tx_packet_data`  in  8  head byte of the TX buffer; combinationally valid
- `clear_toggle`  in  1  forces the next DATA PID to DATA0
- `shifter_ready`  in  1  serializer can accept a byte this cycle
- `eop_done`  in  1  serializer has finished driving EOP
- `load_byte`  out  1  `tx_byte` is valid and handed to the serializer
- `tx_byte`  out  8  byte to serialize, LSB first
- `get_tx_packet_data`  out  1  pop pulse to the TX buffer
- `send_eop`  out  1  EOP request pulse
- `tx_busy`  out  1  high in every state except IDLE
- `tx_done`  out  1  one-cycle pulse when a packet has completed
- `tx_error`  out  1  one-cycle pulse on an invalid `tx_packet`

## Operation
- Reset: state IDLE. All outputs are 0, `tx_byte`=0x00, CRC register=0xFFFF, byte counter=0, data toggle=0.
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, WAIT_EOP, DONE.
- IDLE, `tx_start`=1:
  - Valid type: latch type and min(`buffer_occupancy`, `MAX_PAYLOAD`) into the byte counter, preset CRC to 0xFFFF, go to SYNC.
  - Invalid type: pulse `tx_error`, stay in IDLE.
- Byte handshake: in SYNC, PID, DATA, CRC_LO and CRC_HI, `load_byte`=1 only in cycles where `shifter_ready`=1. The state advances on that same edge. With `shifter_ready`=0 the FSM holds and `tx_byte` stays stable.
- SYNC: `tx_byte`=0x80. Next state is PID.
- PID: `tx_byte` is ACK 0xD2, NAK 0x5A, STALL 0x1E, DATA0 0xC3 or DATA1 0x4B.
  - Handshake types go to EOP.
  - DATA goes to DATA if the counter is nonzero, else to CRC_LO.
- DATA:
  - `tx_byte`=`tx_packet_data`. `get_tx_packet_data` pulses in the same cycle as `load_byte`.
  - Per loaded byte: CRC is updated (bytewise) and the counter is decremented.
  - Next state is CRC_LO when the counter reaches 0.
- CRC16:
  - Polynomial 0x8005, reflected, LSB first, init 0xFFFF. The updated register is `crc` = (`crc`>>1) ^ (`crc`[0]^bit ? 0xA001 : 0), applied for 8 bits per byte.
  - CRC_LO sends (~`crc`)[7:0]; CRC_HI sends (~`crc`)[15:8]. Next state is EOP.
- EOP: pulse `send_eop` for one cycle, then WAIT_EOP.
- WAIT_EOP: hold until `eop_done`=1, then DONE.
- DONE: pulse `tx_done` for one cycle and return to IDLE. For DATA packets, the toggle inverts here.
- `clear_toggle` takes effect in any state. If it coincides with the DONE toggle, `clear_toggle` wins (toggle=0).
- `tx_start` outside IDLE is ignored.
- `n_rst` asserted mid-packet aborts immediately to the reset state. No `tx_done` is generated.

## Timing
- `tx_start` to first `load_byte` (SYNC): 1 cycle minimum, because the FSM enters SYNC on the edge after `tx_start`.
- Each byte takes 1 cycle plus however long `shifter_ready` is low.
- `eop_done` to `tx_done`: 1 cycle. `tx_done` to accepting the next `tx_start`: 1 cycle.
- The CRC register updates on the edge of the DATA `load_byte`. CRC_LO therefore sees the final value with no bubble.
- All outputs are combinational from state and registers. There is no dependency of any output on `tx_start` in the same cycle.

## Configuration
- `TX_DATA_TOGGLE_EN`
  - Defined: DATA PID alternates DATA0/DATA1 per completed DATA packet. The toggle is reset by `n_rst` or `clear_toggle`.
  - Undefined: every DATA packet uses DATA0 (0xC3). `clear_toggle` is ignored and no toggle register is built.

## Test plan
- ACK request, `shifter_ready`=1 -> `load_byte` bytes 0x80, 0xD2. Then `send_eop` pulse; `eop_done` -> `tx_done` 1 cycle later. No `get_tx_packet_data`.
- DATA, occupancy 9 with buffer "123456789" (0x31..0x39) -> bytes 0x80, 0xC3, 0x31..0x39, 0xC8, 0xB4. Exactly 9 pops.
- DATA, occupancy 0 -> bytes 0x80, 0xC3, 0x00, 0x00, then EOP.
- Two DATA packets back-to-back with `TX_DATA_TOGGLE_EN` -> PIDs 0xC3 then 0x4B. Pulse `clear_toggle`, send a third -> 0xC3. Without the macro -> all 0xC3.
- `shifter_ready` low for 5 cycles during DATA -> `tx_byte` is held, no `load_byte`, no pop. Stream resumes unchanged.
- `tx_packet`=2 -> `tx_error` pulse, `tx_busy` stays 0. `n_rst` asserted in DATA -> IDLE, all outputs 0; the next NAK sends 0x80, 0x5A.
